// File: rtl/mem_loader_if.sv
// Bus bundle for mem_loader: the host byte-download channel plus the sram_wb copy port.
interface mem_loader_if;
    logic        dl_start;
    logic [24:0] dl_base;
    logic        dl_virt;
    logic        dl_valid;
    logic [7:0]  dl_data;
    logic        dl_ready;
    logic        dl_end;
    logic        mem_copy;
    logic        mem_copy_virt;
    logic [24:0] mem_copy_addr;
    logic [15:0] mem_copy_data;
    logic        mem_copy_we;
    logic        mem_copy_rd;

    modport master (
        output dl_start, dl_base, dl_virt, dl_valid, dl_data, dl_end,
        input  dl_ready, mem_copy, mem_copy_virt, mem_copy_addr, mem_copy_data,
               mem_copy_we, mem_copy_rd
    );

    modport slave (
        input  dl_start, dl_base, dl_virt, dl_valid, dl_data, dl_end,
        output dl_ready, mem_copy, mem_copy_virt, mem_copy_addr, mem_copy_data,
               mem_copy_we, mem_copy_rd
    );
endinterface

// File: rtl/mem_loader.sv
// Packs the host download byte stream into little-endian words, buffers them and
// replays them as fixed-window write strobes on the sram_wb copy port.
module mem_loader #(
    parameter int ACCESS_CYCLES = 32,
    parameter int STROBE_CYCLES = 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic         clk_ram,
    input  logic         init_n,
    mem_loader_if.slave  bus,
    output logic         busy,
    output logic         done,
    output logic [15:0]  word_count
);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(ACCESS_CYCLES);
    localparam int GAP_CYCLES = ACCESS_CYCLES - STROBE_CYCLES - 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_SETUP  = 3'd2,
        S_STROBE = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_r, state_nx;
    logic [15:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic [7:0]        lo_byte_r;
    logic              have_lo_r, push_r, end_seen_r;
    logic [15:0]       push_word_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r, done_r, mem_copy_r, virt_r, we_r;
    logic [24:0]       addr_r;
    logic [15:0]       data_r, word_count_r;
    logic              fifo_full_s, fifo_empty_s, ready_s, accept_s, flush_s;
    logic              start_s, pop_s, cnt_zero_s, word_done_s;

    assign fifo_full_s  = (count_r == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty_s = (count_r == (PTR_W+1)'(0));
    assign ready_s      = busy_r & ~end_seen_r & ~fifo_full_s;
    assign accept_s     = bus.dl_valid & ready_s;
    // A lone low byte left at end of stream becomes a word with a zero high byte.
    assign flush_s      = end_seen_r & have_lo_r & ~push_r & ~fifo_full_s;
    assign cnt_zero_s   = (cnt_r == CNT_W'(0));
    assign word_done_s  = (state_r == S_GAP) & cnt_zero_s;

    // FSM state register
    always_ff @(posedge clk_ram or negedge init_n) begin
        if (!init_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // FSM next-state and per-cycle control strobes
    always_comb begin
        state_nx = state_r;
        start_s  = 1'b0;
        pop_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.dl_start) begin
                    state_nx = S_ARM;
                    start_s  = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_ARM: begin
                if (!fifo_empty_s) begin
                    state_nx = S_SETUP;
                    pop_s    = 1'b1;
                end else if (end_seen_r && !have_lo_r && !push_r) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_ARM;
                end
            end
            S_SETUP:  state_nx = S_STROBE;
            S_STROBE: begin
                if (cnt_zero_s) begin
                    state_nx = S_GAP;
                end else begin
                    state_nx = S_STROBE;
                end
            end
            S_GAP: begin
                if (cnt_zero_s) begin
                    state_nx = S_ARM;
                end else begin
                    state_nx = S_GAP;
                end
            end
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Byte pairing and end-of-stream tracking; completed words are pushed a cycle later
    always_ff @(posedge clk_ram or negedge init_n) begin
        if (!init_n) begin
            lo_byte_r   <= 8'h00;
            have_lo_r   <= 1'b0;
            push_r      <= 1'b0;
            push_word_r <= 16'h0000;
            end_seen_r  <= 1'b0;
        end else if (start_s) begin
            have_lo_r  <= 1'b0;
            push_r     <= 1'b0;
            end_seen_r <= 1'b0;
        end else begin
            push_r <= 1'b0;
            if (state_r != S_IDLE && bus.dl_end) begin
                end_seen_r <= 1'b1;
            end
            if (accept_s) begin
                if (have_lo_r) begin
                    push_r      <= 1'b1;
                    push_word_r <= {bus.dl_data, lo_byte_r};
                    have_lo_r   <= 1'b0;
                end else begin
                    lo_byte_r <= bus.dl_data;
                    have_lo_r <= 1'b1;
                end
            end else if (flush_s) begin
                push_r      <= 1'b1;
                push_word_r <= {8'h00, lo_byte_r};
                have_lo_r   <= 1'b0;
            end
        end
    end

    // Word FIFO
    always_ff @(posedge clk_ram or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 16'h0000;
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= (PTR_W+1)'(0);
        end else begin
            if (push_r) begin
                fifo_mem_r[wr_ptr_r] <= push_word_r;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_r, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Strobe and gap timer
    always_ff @(posedge clk_ram or negedge init_n) begin
        if (!init_n) begin
            cnt_r <= CNT_W'(0);
        end else if (state_r == S_SETUP) begin
            cnt_r <= CNT_W'(STROBE_CYCLES - 1);
        end else if (state_r == S_STROBE && cnt_zero_s) begin
            cnt_r <= CNT_W'(GAP_CYCLES - 1);
        end else if (!cnt_zero_s) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end
    end

    // Registered copy-port and session outputs, driven from the next state
    always_ff @(posedge clk_ram or negedge init_n) begin
        if (!init_n) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            mem_copy_r   <= 1'b0;
            virt_r       <= 1'b0;
            we_r         <= 1'b0;
            addr_r       <= 25'h0000000;
            data_r       <= 16'h0000;
            word_count_r <= 16'h0000;
        end else begin
            we_r   <= (state_nx == S_STROBE);
            done_r <= (state_nx == S_DONE);
            if (pop_s) begin
                data_r <= fifo_mem_r[rd_ptr_r];
            end
            if (start_s) begin
                busy_r       <= 1'b1;
                mem_copy_r   <= 1'b1;
                virt_r       <= bus.dl_virt;
                addr_r       <= bus.dl_base & 25'h1FFFFFE;
                word_count_r <= 16'h0000;
            end else if (state_nx == S_DONE) begin
                busy_r     <= 1'b0;
                mem_copy_r <= 1'b0;
            end else if (word_done_s) begin
                addr_r       <= addr_r + 25'd2;
                word_count_r <= word_count_r + 16'd1;
            end
        end
    end

    assign bus.dl_ready      = ready_s;
    assign bus.mem_copy      = mem_copy_r;
    assign bus.mem_copy_virt = virt_r;
    assign bus.mem_copy_addr = addr_r;
    assign bus.mem_copy_data = data_r;
    assign bus.mem_copy_we   = we_r;
    assign bus.mem_copy_rd   = 1'b0;
    assign busy              = busy_r;
    assign done              = done_r;
    assign word_count        = word_count_r;
endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: directed vector table, multi-cycle corner sequences and random
// sessions scored against a word-level model of the download stream.
module tb_mem_loader;
    localparam int ACCESS = 32;
    localparam int STROBE = 8;
    localparam int DEPTH  = 4;

    logic        clk    = 1'b0;
    logic        init_n = 1'b0;
    logic        busy, done;
    logic [15:0] word_count;

    mem_loader_if bus ();

    mem_loader #(.ACCESS_CYCLES(ACCESS), .STROBE_CYCLES(STROBE), .FIFO_DEPTH(DEPTH)) dut (
        .clk_ram    (clk),
        .init_n     (init_n),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] addr;
        logic [15:0] data;
        logic        virt;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [24:0] base;
        int          n;
        logic [31:0] bytes;
        bit          coincide;
        bit          mid_start;
        int          exp_words;
        logic [24:0] a0, a1;
        logic [15:0] w0, w1;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    wr_t         got_q[$];
    logic [7:0]  bytes_q[$];
    vec_t        vecs[5];
    logic        m_prev_we = 1'b0;
    logic [24:0] m_prev_addr = 25'h0;
    logic [15:0] m_prev_data = 16'h0;
    int          m_len = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Copy-port monitor: captures each write at the rising strobe and checks its shape
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!init_n) begin
                m_prev_we = 1'b0;
                m_len     = 0;
            end else begin
                if (bus.mem_copy_we && !m_prev_we) begin
                    check("addr_stable_at_we_rise", bus.mem_copy_addr, m_prev_addr);
                    check("data_stable_at_we_rise", bus.mem_copy_data, m_prev_data);
                    check("mem_copy_high_during_we", bus.mem_copy, 1);
                    check("mem_copy_rd_low", bus.mem_copy_rd, 0);
                    got_q.push_back('{bus.mem_copy_addr, bus.mem_copy_data, bus.mem_copy_virt, cyc});
                    m_len = 1;
                end else if (bus.mem_copy_we) begin
                    check("addr_hold", bus.mem_copy_addr, m_prev_addr);
                    check("data_hold", bus.mem_copy_data, m_prev_data);
                    m_len++;
                end else if (m_prev_we) begin
                    check("strobe_length", m_len, STROBE);
                end
                if (done) begin
                    done_cnt++;
                    check("copy_and_busy_low_at_done", {bus.mem_copy, busy}, 0);
                end
                m_prev_we = bus.mem_copy_we;
            end
            m_prev_addr = bus.mem_copy_addr;
            m_prev_data = bus.mem_copy_data;
        end
    end

    // One download session from bytes_q, scored against the word-level model.
    task automatic run_session(input logic [24:0] base, input logic virt, input bit coincide,
                               input int gap_pct, input bit mid_start, input string tag,
                               output bit stalled);
        int n, nw, i, guard, done_base;
        n         = bytes_q.size();
        nw        = (n + 1) / 2;
        stalled   = 1'b0;
        got_q.delete();
        done_base = done_cnt;
        @(negedge clk);
        check({tag, " busy_before_start"}, busy, 0);
        bus.dl_start = 1'b1;
        bus.dl_base  = base;
        bus.dl_virt  = virt;
        @(negedge clk);
        bus.dl_start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1);
        check({tag, " mem_copy_after_start"}, bus.mem_copy, 1);
        i = 0;
        guard = 0;
        while (i < n && guard < 5000) begin
            if (mid_start && guard == 3) begin
                bus.dl_start = 1'b1;
                bus.dl_base  = base ^ 25'h00AAAAA;
            end else begin
                bus.dl_start = 1'b0;
            end
            if ($urandom_range(99) < gap_pct) begin
                bus.dl_valid = 1'b0;
                bus.dl_end   = 1'b0;
            end else begin
                bus.dl_valid = 1'b1;
                bus.dl_data  = bytes_q[i];
                bus.dl_end   = coincide && (i == n - 1) && bus.dl_ready;
                if (bus.dl_ready) i++;
                else stalled = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        bus.dl_start = 1'b0;
        bus.dl_valid = 1'b0;
        bus.dl_end   = 1'b0;
        check({tag, " all_bytes_accepted"}, i, n);
        if (!coincide || n == 0) begin
            bus.dl_end = 1'b1;
            @(negedge clk);
            bus.dl_end = 1'b0;
        end
        guard = 0;
        while (!done && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " done_seen"}, done, 1);
        check({tag, " word_count"}, word_count, nw % 65536);
        @(negedge clk);
        check({tag, " done_one_cycle"}, done, 0);
        repeat (3) @(negedge clk);
        check({tag, " done_pulses"}, done_cnt - done_base, 1);
        check({tag, " write_count"}, got_q.size(), nw);
        for (int k = 0; k < nw && k < got_q.size(); k++) begin
            logic [7:0]  hi;
            longint      a;
            logic [24:0] ea;
            hi = (2 * k + 1 < n) ? bytes_q[2 * k + 1] : 8'h00;
            a  = ((longint'(base) / 2) * 2 + 2 * k) % 33554432;
            ea = a[24:0];
            check({tag, " write_addr"}, got_q[k].addr, ea);
            check({tag, " write_data"}, got_q[k].data, {hi, bytes_q[2 * k]});
            check({tag, " write_virt"}, got_q[k].virt, virt);
        end
    endtask

    initial begin
        bit          stalled;
        int          guard;
        int          wc_before, dc_before;
        logic [31:0] b;

        bus.dl_start = 1'b0;
        bus.dl_base  = 25'h0;
        bus.dl_virt  = 1'b0;
        bus.dl_valid = 1'b0;
        bus.dl_data  = 8'h00;
        bus.dl_end   = 1'b0;

        vecs[0] = '{25'h0080000, 4, 32'h44332211, 1'b0, 1'b0, 2, 25'h0080000, 25'h0080002, 16'h2211, 16'h4433};
        vecs[1] = '{25'h0001001, 3, 32'h00CCBBAA, 1'b1, 1'b0, 2, 25'h0001000, 25'h0001002, 16'hBBAA, 16'h00CC};
        vecs[2] = '{25'h1FFFFFF, 4, 32'h04030201, 1'b0, 1'b1, 2, 25'h1FFFFFE, 25'h0000000, 16'h0201, 16'h0403};
        vecs[3] = '{25'h0123456, 0, 32'h00000000, 1'b0, 1'b0, 0, 25'h0, 25'h0, 16'h0, 16'h0};
        vecs[4] = '{25'h0000010, 1, 32'h0000005A, 1'b1, 1'b0, 1, 25'h0000010, 25'h0, 16'h005A, 16'h0};

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_word_count", word_count, 0);
        check("reset_copy_flags", {bus.mem_copy, bus.mem_copy_we, bus.mem_copy_rd, bus.mem_copy_virt, bus.dl_ready}, 0);
        check("reset_addr", bus.mem_copy_addr, 0);
        check("reset_data", bus.mem_copy_data, 0);
        init_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            bytes_q.delete();
            b = vecs[v].bytes;
            for (int k = 0; k < vecs[v].n; k++) bytes_q.push_back(b[8 * k +: 8]);
            run_session(vecs[v].base, 1'b0, vecs[v].coincide, 0, vecs[v].mid_start, $sformatf("vec%0d", v), stalled);
            check($sformatf("vec%0d table_words", v), got_q.size(), vecs[v].exp_words);
            if (got_q.size() >= 1 && vecs[v].exp_words >= 1) begin
                check($sformatf("vec%0d table_a0", v), got_q[0].addr, vecs[v].a0);
                check($sformatf("vec%0d table_w0", v), got_q[0].data, vecs[v].w0);
            end
            if (got_q.size() >= 2 && vecs[v].exp_words >= 2) begin
                check($sformatf("vec%0d table_a1", v), got_q[1].addr, vecs[v].a1);
                check($sformatf("vec%0d table_w1", v), got_q[1].data, vecs[v].w1);
            end
        end

        wc_before = word_count;
        dc_before = done_cnt;
        got_q.delete();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.dl_valid = k[0];
            bus.dl_end   = k[1];
            bus.dl_data  = 8'(k);
            check("idle_outputs_low", {bus.mem_copy, busy, bus.dl_ready}, 0);
        end
        @(negedge clk);
        bus.dl_valid = 1'b0;
        bus.dl_end   = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_word_count", word_count, wc_before);
        check("idle_no_done", done_cnt, dc_before);
        check("idle_no_writes", got_q.size(), 0);

        bytes_q.delete();
        for (int k = 0; k < 20; k++) bytes_q.push_back(8'($urandom));
        run_session(25'h0200000, 1'b1, 1'b1, 0, 1'b0, "backpressure", stalled);
        check("backpressure ready_dropped", stalled, 1);
        for (int k = 1; k < got_q.size(); k++) begin
            check("backpressure write_spacing", got_q[k].cyc - got_q[k - 1].cyc, ACCESS + 1);
        end

        @(negedge clk);
        bus.dl_start = 1'b1;
        bus.dl_base  = 25'h0040000;
        @(negedge clk);
        bus.dl_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.dl_valid = 1'b1;
            bus.dl_data  = 8'(16 + k);
            @(negedge clk);
        end
        bus.dl_valid = 1'b0;
        guard = 0;
        while (!bus.mem_copy_we && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rst_strobe_reached", bus.mem_copy_we, 1);
        repeat (3) @(negedge clk);
        #2 init_n = 1'b0;
        #1;
        check("rst_async_outputs_low", {bus.mem_copy, bus.mem_copy_we, busy}, 0);
        check("rst_word_count", word_count, 0);
        repeat (2) @(negedge clk);
        init_n = 1'b1;
        bytes_q.delete();
        for (int k = 0; k < 4; k++) bytes_q.push_back(8'($urandom));
        run_session(25'h0002000, 1'b0, 1'b0, 0, 1'b0, "after_reset", stalled);

        for (int s = 0; s < 8; s++) begin
            int n;
            n = $urandom_range(11);
            bytes_q.delete();
            for (int k = 0; k < n; k++) bytes_q.push_back(8'($urandom));
            run_session(25'($urandom), 1'($urandom), 1'($urandom), $urandom_range(60), 1'b0,
                        $sformatf("rand%0d", s), stalled);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
